// File: rtl/edge_threshold_stage.sv
// Border-masking threshold binariser downstream of the convolution filter.
// Tracks raster position, emits end-of-frame and a per-frame edge-pixel count.
module edge_threshold_stage #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int W          = 8,
  parameter int BORDER     = 1,
  parameter int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [W-1:0]     x_data,
  input  logic [W-1:0]     threshold,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [W-1:0]     y_data,
  output logic             y_last,
  output logic             stat_valid,
  output logic [CNT_W-1:0] stat_count
);

  localparam int CW = $clog2(IMG_WIDTH+1);
  localparam int RW = $clog2(IMG_HEIGHT+1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(IMG_WIDTH-BORDER);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT-1);
  localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI   = RW'(IMG_HEIGHT-BORDER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             run_q;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [W-1:0]     thr_q;
  logic [CNT_W-1:0] count;

  logic [W-1:0]     buf0_data_p1, buf1_data_p1;
  logic             buf0_last_p1, buf1_last_p1;
  logic [1:0]       occ_p1;

  logic             accept, pop, last_px, border_px, edge_px;
  logic [W-1:0]     thr_eff, pix_p0;

  function automatic logic [W-1:0] binarise(input logic is_edge);
    return is_edge ? {W{1'b1}} : {W{1'b0}};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    return c;
  endfunction

  // Stage p0: classify the pixel being accepted this cycle
  assign accept    = x_valid && x_ready;
  assign pop       = y_valid && y_ready;
  // The first pixel of a frame is judged against the live threshold it latches.
  assign thr_eff   = (state == S_IDLE) ? threshold : thr_q;
  assign last_px   = (col == COL_LAST) && (row == ROW_LAST);
  assign border_px = (col < COL_LO) || (col >= COL_HI) ||
                     (row < ROW_LO) || (row >= ROW_HI);
  assign edge_px   = !border_px && (x_data >= thr_eff);
  assign pix_p0    = binarise(edge_px);

  always_comb begin
    state_nxt  = state;
    x_ready    = 1'b0;
    stat_valid = 1'b0;
    case (state)
      S_IDLE: begin
        x_ready = run_q && (occ_p1 != 2'd2);
        if (accept)
          state_nxt = last_px ? S_REPORT : S_ACTIVE;
      end
      S_ACTIVE: begin
        x_ready = run_q && (occ_p1 != 2'd2);
        if (accept && last_px)
          state_nxt = S_REPORT;
      end
      S_REPORT: begin
        stat_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q      <= '0;
      count      <= '0;
      stat_count <= '0;
    end else if (accept) begin
      if (state == S_IDLE)
        thr_q <= threshold;
      if (last_px) begin
        stat_count <= sat_inc(count, edge_px);
        count      <= '0;
      end else begin
        count <= sat_inc(count, edge_px);
      end
    end
  end

  // Stage p1: two-entry skid buffer, entry 0 is the head driving y_*
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_p1       <= 2'd0;
      buf0_data_p1 <= '0;
      buf0_last_p1 <= 1'b0;
      buf1_data_p1 <= '0;
      buf1_last_p1 <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b11: begin
          // Only reachable with one entry held, since a full buffer blocks x_ready.
          buf0_data_p1 <= pix_p0;
          buf0_last_p1 <= last_px;
        end
        2'b01: begin
          buf0_data_p1 <= buf1_data_p1;
          buf0_last_p1 <= buf1_last_p1;
          occ_p1       <= occ_p1 - 2'd1;
        end
        2'b10: begin
          if (occ_p1 == 2'd0) begin
            buf0_data_p1 <= pix_p0;
            buf0_last_p1 <= last_px;
          end else begin
            buf1_data_p1 <= pix_p0;
            buf1_last_p1 <= last_px;
          end
          occ_p1 <= occ_p1 + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign y_valid = (occ_p1 != 2'd0);
  assign y_data  = buf0_data_p1;
  assign y_last  = buf0_last_p1;

endmodule

// File: tb/tb_edge_threshold_stage.sv
// Directed bench for edge_threshold_stage on an 8x6 frame (BORDER=1 main
// instance, BORDER=0 companion instance fed the same stream).
module tb_edge_threshold_stage;
  localparam int IW    = 8;
  localparam int IH    = 6;
  localparam int CNT_W = $clog2(IW*IH+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             x_valid, x_ready;
  logic [7:0]       x_data, threshold;
  logic             y_valid, y_ready, y_last, stat_valid;
  logic [7:0]       y_data;
  logic [CNT_W-1:0] stat_count;
  logic             b0_x_ready, b0_y_valid, b0_y_last, b0_stat_valid;
  logic [7:0]       b0_y_data;
  logic [CNT_W-1:0] b0_stat_count;

  always #5 clk = ~clk;

  edge_threshold_stage #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8), .BORDER(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .threshold(threshold), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_last(y_last), .stat_valid(stat_valid), .stat_count(stat_count));

  edge_threshold_stage #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8), .BORDER(0), .CNT_W(CNT_W)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(b0_x_ready), .x_data(x_data),
    .threshold(threshold), .y_valid(b0_y_valid), .y_ready(y_ready), .y_data(b0_y_data),
    .y_last(b0_y_last), .stat_valid(b0_stat_valid), .stat_count(b0_stat_count));

  int         compared = 0;
  int         mismatched = 0;
  logic [8:0] exp_q[$];
  int         stat_log[$];
  int         m_col, m_row, m_cnt, exp_stat;
  logic [7:0] m_thr;
  bit         m_active, sv_pending, prev_stall, chk_b0;
  logic [7:0] prev_yd;
  logic       prev_yl;
  int         bubbles, full_seen, b0_stat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_col = 0; m_row = 0; m_cnt = 0; exp_stat = 0;
    m_thr = 8'h00; m_active = 0; sv_pending = 0; prev_stall = 0;
  endtask

  task automatic model_accept(input logic [7:0] d, input logic [7:0] thr);
    bit border_b, edge_b, last_b;
    if (!m_active) begin
      m_thr = thr;
      m_active = 1;
    end
    border_b = (m_col < 1) || (m_col >= IW-1) || (m_row < 1) || (m_row >= IH-1);
    edge_b   = !border_b && (d >= m_thr);
    last_b   = (m_col == IW-1) && (m_row == IH-1);
    exp_q.push_back({last_b, edge_b ? 8'hFF : 8'h00});
    if (edge_b) m_cnt++;
    if (last_b) begin
      exp_stat = m_cnt; m_cnt = 0; m_active = 0; sv_pending = 1;
    end
    if (m_col == IW-1) begin
      m_col = 0;
      m_row = (m_row == IH-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic step(input bit xv, input logic [7:0] xd, input bit yr, output bit acc);
    logic xr, yv, yl, sv;
    logic [7:0] yd;
    logic [CNT_W-1:0] sc;
    logic [8:0] front;
    @(negedge clk);
    xr = x_ready; yv = y_valid; yd = y_data; yl = y_last; sv = stat_valid; sc = stat_count;
    chk("y_valid", 32'(yv), 32'(exp_q.size() != 0));
    chk("stat_valid", 32'(sv), 32'(sv_pending));
    if (sv) begin
      chk("stat_count", 32'(sc), 32'(exp_stat));
      stat_log.push_back(int'(sc));
    end
    sv_pending = 0;
    if (exp_q.size() == 2) begin
      full_seen++;
      chk("x_ready_full", 32'(xr), 32'h0);
    end
    if (prev_stall) begin
      chk("stall_y_data", 32'(yd), 32'(prev_yd));
      chk("stall_y_last", 32'(yl), 32'(prev_yl));
    end
    if (b0_stat_valid) b0_stat = int'(b0_stat_count);
    x_valid = xv; x_data = xd; y_ready = yr;
    acc = xv && xr;
    if (xv && !xr) bubbles++;
    if (yv && yr && exp_q.size() != 0) begin
      front = exp_q.pop_front();
      chk("y_data", 32'(yd), 32'(front[7:0]));
      chk("y_last", 32'(yl), 32'(front[8]));
    end
    if (chk_b0 && b0_y_valid && yr)
      chk("b0_y_data", 32'(b0_y_data), 32'hFF);
    prev_stall = yv && !yr; prev_yd = yd; prev_yl = yl;
    if (acc) model_accept(xd, threshold);
  endtask

  task automatic run_pixels(input int n, input int mode, input bit rnd,
                            input int sw_at, input logic [7:0] thr2);
    int k = 0;
    int guard = 0;
    bit acc;
    logic [7:0] d;
    while (k < n && guard < 2000) begin
      if (k == sw_at) threshold = thr2;
      d = (mode == 0) ? 8'((k % 48) * 5) : 8'h00;
      step(1'b1, d, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      if (acc) k++;
      guard++;
    end
    if (k < n) chk("run_timeout", 32'(k), 32'(n));
  endtask

  task automatic drain();
    int guard = 0;
    bit acc;
    while ((exp_q.size() != 0 || sv_pending) && guard < 100) begin
      step(1'b0, 8'h00, 1'b1, acc);
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    x_valid = 1'b0; x_data = 8'h00; threshold = 8'h80; y_ready = 1'b0;
    chk_b0 = 0; bubbles = 0; full_seen = 0; b0_stat = -1;
    model_reset();

    // Reset held with x_valid asserted
    x_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_x_ready", 32'(x_ready), 32'h0);
      chk("rst_y_valid", 32'(y_valid), 32'h0);
      chk("rst_stat_valid", 32'(stat_valid), 32'h0);
      chk("rst_stat_count", 32'(stat_count), 32'h0);
    end
    x_valid = 1'b0;
    rst_n = 1'b1;

    // Ramp i*5 against 0x80: interior edges are pixels 26..30 and 33..38
    stat_log.delete();
    run_pixels(48, 0, 1'b0, -1, 8'h00);
    drain();
    chk("t2_pulses", 32'(stat_log.size()), 32'd1);
    if (stat_log.size() > 0) chk("t2_stat", 32'(stat_log[0]), 32'd11);

    // Same frame under random output backpressure
    stat_log.delete(); full_seen = 0;
    run_pixels(48, 0, 1'b1, -1, 8'h00);
    drain();
    chk("t3_pulses", 32'(stat_log.size()), 32'd1);
    if (stat_log.size() > 0) chk("t3_stat", 32'(stat_log[0]), 32'd11);
    chk("t3_full_seen", 32'(full_seen > 0), 32'd1);

    // Threshold drops to 0x10 mid-frame; only the second frame sees it
    stat_log.delete(); bubbles = 0; threshold = 8'h80;
    run_pixels(96, 0, 1'b0, 20, 8'h10);
    drain();
    chk("t4_bubbles", 32'(bubbles), 32'd1);
    chk("t4_pulses", 32'(stat_log.size()), 32'd2);
    if (stat_log.size() > 1) begin
      chk("t4_stat_f1", 32'(stat_log[0]), 32'd11);
      chk("t4_stat_f2", 32'(stat_log[1]), 32'd24);
    end

    // Zero threshold, zero data: every non-border pixel is an edge
    stat_log.delete(); threshold = 8'h00; chk_b0 = 1; b0_stat = -1;
    run_pixels(48, 1, 1'b0, -1, 8'h00);
    drain();
    chk_b0 = 0;
    chk("t5_pulses", 32'(stat_log.size()), 32'd1);
    if (stat_log.size() > 0) chk("t5_stat_b1", 32'(stat_log[0]), 32'd24);
    chk("t5_stat_b0", 32'(b0_stat), 32'd48);

    // Reset at pixel 30, then a full clean frame
    stat_log.delete(); threshold = 8'h80;
    run_pixels(30, 0, 1'b0, -1, 8'h00);
    @(negedge clk);
    rst_n = 1'b0; x_valid = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("t6_rst_stat_valid", 32'(stat_valid), 32'h0);
      chk("t6_rst_y_valid", 32'(y_valid), 32'h0);
      chk("t6_rst_x_ready", 32'(x_ready), 32'h0);
    end
    rst_n = 1'b1;
    run_pixels(48, 0, 1'b0, -1, 8'h00);
    drain();
    chk("t6_pulses", 32'(stat_log.size()), 32'd1);
    if (stat_log.size() > 0) chk("t6_stat", 32'(stat_log[0]), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
